beta_pipe_ctl: RTL and testbench
================================

# beta_pipe_ctl

Pipeline sequencing controller for the 5-stage Beta (IF, RF, ALU, MEM, WB). It generates the per-stage destination tags consumed by the operand bypass units and the per-stage load enables. It also injects bubbles on bypass stalls, annuls the IF slot on taken branches, freezes the pipe while data memory is busy, and injects the interrupt branch into RF. It sits beside the RF-stage decode logic and drives the two bypass units (operands A and B).

## Interface
- No parameters.
- clk  in  1  pipeline clock.
- rst_n  in  1  reset; asynchronous, active-low.
- rf_valid  in  1  RF holds a real (non-NOP) instruction.
- rf_dest  in  5  RF destination register (R31 for no-write).
- rf_class  in  2  RF result class: 00 pending (LD, ready in WB), 01 ALU, 10 PC+4 link, 11 no write.
- stall_a, stall_b  in  1  stall requests from the two bypass units.
- br_taken  in  1  RF instruction redirects PC.
- mem_busy  in  1  data memory not ready for the MEM-stage access.
- irq, irq_en  in  1  external interrupt request; enable (0 in supervisor mode).
- aP0, aP1, aP2  out  7  {class[1:0], dest[4:0]} tags for ALU, MEM, WB.
- pc_en, ir_if_en  out  1  load PC / IF->RF instruction register.
- if_annul  out  1  load NOP into IF->RF register.
- rf_bubble  out  1  ALU stage receives NOP instead of RF instruction.
- pipe_en  out  1  advance ALU->MEM->WB registers.
- irq_take  out  1  RF instruction replaced by BR(XAddr), XP link.
- wb_we  out  1  register-file write in WB.

## Operation
- BUBBLE tag = {11, 11111}. Class 11 and dest 31 never generate a stall or forward.
- freeze = mem_busy; stall = (stall_a | stall_b) & !freeze.
- While freeze: pc_en = ir_if_en = pipe_en = 0 and all tags hold. Nothing else acts: no branch, no interrupt, no counter step.
- Not frozen: pipe_en = 1. Tags shift: aP2 <= aP1, aP1 <= aP0, aP0 <= new tag.
- New tag selection, in priority order:
  - stall or !rf_valid: BUBBLE.
  - irq_take: {10, 11110} (XP).
  - otherwise {rf_class, rf_dest}.
- Stall: pc_en = ir_if_en = 0, rf_bubble = 1. br_taken is ignored, because the RF instruction is re-executed next cycle.
- Branch (br_taken & !stall & !freeze): pc_en = ir_if_en = 1, if_annul = 1.
- Normal cycle: pc_en = ir_if_en = 1, if_annul = rf_bubble = 0.
- wb_we = (aP2[6:5] != 11) & (aP2[4:0] != 31) & pipe_en.
- Interrupt FSM:
  - RUN: irq & irq_en & !stall & !freeze & rf_valid → irq_take = 1, if_annul = 1, go MASK, cnt = 3.
  - MASK: irq_take blocked. cnt decrements on each non-frozen cycle. At cnt = 1 with decrement, go RUN. This holds until the injected tag has left WB.
  - irq_take and br_taken together: irq wins, br_taken ignored.

## Timing
- Reset (async, rst_n low):
  - aP0..aP2 = BUBBLE, FSM = RUN, cnt = 0.
  - Combinational outputs pc_en, ir_if_en, pipe_en, if_annul, rf_bubble, irq_take, wb_we are forced 0 while rst_n is low.
- Tags are registered. A tag entering at edge N appears on aP0 after N, aP1 after N+1, aP2 after N+2. Freeze cycles add 1 each.
- All enables and selects are combinational from the current inputs and state, and valid in the same cycle.
- Stall on LD-use: the stall persists while a class-00 tag matches. It clears after that tag reaches aP2, where it becomes forwardable from WB.
- Reset deasserted mid-stream: the first clock edge behaves as a normal cycle with a bubble-filled pipe.

## Structure
- beta_pkg holds:
  - the tag_t typedef (7 bits) and class constants CLS_PEND, CLS_ALU, CLS_LINK, CLS_NONE;
  - BUBBLE and XP_REG (30);
  - the irq FSM enum (RUN, MASK).
- Sub-module beta_tag_pipe holds the three-entry tag shift register with hold (freeze) and async reset to BUBBLE. beta_pipe_ctl holds the FSM, counter and enable logic.

## Test plan
- Reset: hold rst_n low for 3 cycles → aP0..2 = 7'h7F, all enables 0. Release, then feed {01, R3} → aP0 = 7'h23 after 1 edge and aP2 = 7'h23 after 3 edges.
- LD-use: feed {00, R2}, then assert stall_a for 2 cycles → pc_en = 0, rf_bubble = 1 both cycles, aP0 = BUBBLE twice, {00, R2} advances to aP2, stall drops.
- Branch: br_taken = 1 with no stall → if_annul = 1, pc_en = 1. Same with stall_a = 1 → if_annul = 0, pc_en = 0.
- Freeze: mem_busy = 1 for 4 cycles with tags A/B/C in flight → tags hold, pipe_en = 0, wb_we = 0. After release they shift normally.
- Interrupt: irq = irq_en = 1 → irq_take pulses once, new tag 7'h5E. A repeated irq is ignored for 3 non-frozen cycles, then taken again. irq with stall = 1 → not taken until the stall clears.
- Write-enable: aP2 = {11, R5} or {01, R31} → wb_we = 0. aP2 = {01, R5} → wb_we = 1.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared types and constants for the Beta pipeline sequencing controller.
// Tags are {class[1:0], dest[4:0]} as consumed by the bypass units.
`timescale 1ns/1ps
package beta_pkg;

  typedef logic [6:0] tag_t;

  localparam logic [1:0] CLS_PEND = 2'b00;
  localparam logic [1:0] CLS_ALU  = 2'b01;
  localparam logic [1:0] CLS_LINK = 2'b10;
  localparam logic [1:0] CLS_NONE = 2'b11;

  localparam logic [4:0] R31    = 5'd31;
  localparam logic [4:0] XP_REG = 5'd30;

  localparam tag_t BUBBLE = {CLS_NONE, R31};
  localparam tag_t XP_TAG = {CLS_LINK, XP_REG};

  typedef enum logic {
    RUN,
    MASK
  } irq_st_e;

  function automatic logic tag_writes(
    input tag_t t
  );
    return (t[6:5] != CLS_NONE) &&
           (t[4:0] != R31);
  endfunction

endpackage

// File: rtl/beta_pipe_ctl_if.sv
// RF-side inputs and stage controls of the Beta pipeline controller.
// slave is the controller; master is the decode/datapath side.
`timescale 1ns/1ps
interface beta_pipe_ctl_if;
  import beta_pkg::*;

  logic       rf_valid;
  logic [4:0] rf_dest;
  logic [1:0] rf_class;
  logic       stall_a;
  logic       stall_b;
  logic       br_taken;
  logic       mem_busy;
  logic       irq;
  logic       irq_en;

  tag_t       aP0;
  tag_t       aP1;
  tag_t       aP2;
  logic       pc_en;
  logic       ir_if_en;
  logic       if_annul;
  logic       rf_bubble;
  logic       pipe_en;
  logic       irq_take;
  logic       wb_we;

  modport master (
    output rf_valid, rf_dest, rf_class,
    output stall_a, stall_b, br_taken,
    output mem_busy, irq, irq_en,
    input  aP0, aP1, aP2,
    input  pc_en, ir_if_en, if_annul,
    input  rf_bubble, pipe_en,
    input  irq_take, wb_we
  );

  modport slave (
    input  rf_valid, rf_dest, rf_class,
    input  stall_a, stall_b, br_taken,
    input  mem_busy, irq, irq_en,
    output aP0, aP1, aP2,
    output pc_en, ir_if_en, if_annul,
    output rf_bubble, pipe_en,
    output irq_take, wb_we
  );

endinterface

// File: rtl/beta_tag_pipe.sv
// Three-entry destination tag shift register (ALU, MEM, WB).
// Holds while frozen; resets to bubbles.
`timescale 1ns/1ps
module beta_tag_pipe
  import beta_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic hold_i,
  input  tag_t tag_i,
  output tag_t p0_o,
  output tag_t p1_o,
  output tag_t p2_o
);

  tag_t p0_q, p1_q, p2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_q <= BUBBLE;
      p1_q <= BUBBLE;
      p2_q <= BUBBLE;
    end else if (!hold_i) begin
      p0_q <= tag_i;
      p1_q <= p0_q;
      p2_q <= p1_q;
    end
  end

  assign p0_o = p0_q;
  assign p1_o = p1_q;
  assign p2_o = p2_q;

endmodule

// File: rtl/beta_pipe_ctl.sv
// Beta 5-stage sequencing: stage enables, bubbles, annul,
// freeze on data-memory busy and interrupt injection into RF.
`timescale 1ns/1ps
module beta_pipe_ctl
  import beta_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  beta_pipe_ctl_if.slave   bus
);

  irq_st_e    state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic freeze;
  logic stall;
  logic take;
  logic adv;
  tag_t tag_d;
  tag_t p2;

  assign freeze = bus.mem_busy;
  assign stall  = (bus.stall_a | bus.stall_b)
                & ~freeze;
  assign adv    = ~freeze & ~stall;

  assign take = (state_q == RUN) & adv
              & bus.rf_valid
              & bus.irq & bus.irq_en;

  always_comb begin
    tag_d = {bus.rf_class, bus.rf_dest};
    if (stall || !bus.rf_valid) begin
      tag_d = BUBBLE;
    end else if (take) begin
      tag_d = XP_TAG;
    end
  end

  beta_tag_pipe u_tags (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold_i (freeze),
    .tag_i  (tag_d),
    .p0_o   (bus.aP0),
    .p1_o   (bus.aP1),
    .p2_o   (p2)
  );

  assign bus.aP2 = p2;

  // Mask lasts until the injected XP tag has drained past WB.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (take) begin
          state_d = MASK;
          cnt_d   = 2'd3;
        end
      end
      MASK: begin
        if (!freeze) begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_en     = rst_n & adv;
  assign bus.ir_if_en  = rst_n & adv;
  assign bus.if_annul  = rst_n & adv
                       & (bus.br_taken | take);
  assign bus.rf_bubble = rst_n & stall;
  assign bus.pipe_en   = rst_n & ~freeze;
  assign bus.irq_take  = rst_n & take;
  assign bus.wb_we     = rst_n & ~freeze
                       & tag_writes(p2);

endmodule

// File: tb/tb_beta_pipe_ctl.sv
// Scoreboard bench for beta_pipe_ctl: directed plan then random traffic
// checked against a tag-queue reference model.
`timescale 1ns/1ps
module tb_beta_pipe_ctl;

  logic clk;
  logic rst_n;

  beta_pipe_ctl_if bus ();

  beta_pipe_ctl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] p0;
    logic [6:0] p1;
    logic [6:0] p2;
    logic       pc_en;
    logic       ir_if_en;
    logic       if_annul;
    logic       rf_bubble;
    logic       pipe_en;
    logic       irq_take;
    logic       wb_we;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference: in-flight tags (ALU, MEM, WB) and non-frozen
  // cycles elapsed since the last interrupt was injected.
  logic [6:0] mp[3];
  int         since;

  task automatic chk(input string nm,
                     input logic [6:0] act,
                     input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic r,
                       input logic v,
                       input logic [4:0] d,
                       input logic [1:0] c,
                       input logic sa,
                       input logic sb,
                       input logic br,
                       input logic mb,
                       input logic iq,
                       input logic ie);
    exp_t e;
    logic frz, stl, tk;
    logic [6:0] nt;
    @(negedge clk);
    rst_n        = r;
    bus.rf_valid = v;
    bus.rf_dest  = d;
    bus.rf_class = c;
    bus.stall_a  = sa;
    bus.stall_b  = sb;
    bus.br_taken = br;
    bus.mem_busy = mb;
    bus.irq      = iq;
    bus.irq_en   = ie;
    if (!r) begin
      mp[0] = 7'h7F;
      mp[1] = 7'h7F;
      mp[2] = 7'h7F;
      since = 3;
    end
    frz = mb;
    stl = (sa | sb) & ~frz;
    tk  = r & ~frz & ~stl & v & iq & ie
        & (since >= 3);
    e.p0        = mp[0];
    e.p1        = mp[1];
    e.p2        = mp[2];
    e.pc_en     = r & ~frz & ~stl;
    e.ir_if_en  = e.pc_en;
    e.if_annul  = e.pc_en & (br | tk);
    e.rf_bubble = r & stl;
    e.pipe_en   = r & ~frz;
    e.irq_take  = tk;
    e.wb_we     = e.pipe_en
                & (mp[2][6:5] != 2'b11)
                & (mp[2][4:0] != 5'd31);
    exp_q.push_back(e);
    if (r && !frz) begin
      if (stl || !v)  nt = 7'h7F;
      else if (tk)    nt = 7'h5E;
      else            nt = {c, d};
      mp[2] = mp[1];
      mp[1] = mp[0];
      mp[0] = nt;
      if (tk)             since = 0;
      else if (since < 3) since++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1, 0, 5'd31, 2'b11,
            0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("aP0", bus.aP0, e.p0);
        chk("aP1", bus.aP1, e.p1);
        chk("aP2", bus.aP2, e.p2);
        chk("pc_en", 7'(bus.pc_en), 7'(e.pc_en));
        chk("ir_if_en", 7'(bus.ir_if_en),
            7'(e.ir_if_en));
        chk("if_annul", 7'(bus.if_annul),
            7'(e.if_annul));
        chk("rf_bubble", 7'(bus.rf_bubble),
            7'(e.rf_bubble));
        chk("pipe_en", 7'(bus.pipe_en),
            7'(e.pipe_en));
        chk("irq_take", 7'(bus.irq_take),
            7'(e.irq_take));
        chk("wb_we", 7'(bus.wb_we), 7'(e.wb_we));
        cyc++;
      end
    end
  end

  initial begin : stim
    logic busy;
    int   w;
    rst_n        = 1'b0;
    bus.rf_valid = 1'b0;
    bus.rf_dest  = 5'd31;
    bus.rf_class = 2'b11;
    bus.stall_a  = 1'b0;
    bus.stall_b  = 1'b0;
    bus.br_taken = 1'b0;
    bus.mem_busy = 1'b0;
    bus.irq      = 1'b0;
    bus.irq_en   = 1'b0;

    // reset with busy inputs must still force enables low
    repeat (3)
      drive(0, 1, 5'd3, 2'b01, 0, 0, 1, 0, 1, 1);
    drive(1, 1, 5'd3, 2'b01, 0, 0, 0, 0, 0, 0);
    idle(3);

    // LD-use stall
    drive(1, 1, 5'd2, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 5'd4, 2'b01, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 5'd4, 2'b01, 1, 0, 1, 0, 0, 0);
    drive(1, 1, 5'd4, 2'b01, 0, 0, 0, 0, 0, 0);
    idle(2);

    // branch without and with stall
    drive(1, 1, 5'd6, 2'b01, 0, 0, 1, 0, 0, 0);
    drive(1, 1, 5'd6, 2'b01, 1, 0, 1, 0, 0, 0);
    drive(1, 1, 5'd6, 2'b01, 0, 1, 1, 0, 0, 0);

    // freeze with A/B/C in flight
    drive(1, 1, 5'd7, 2'b01, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 5'd8, 2'b10, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 5'd9, 2'b00, 0, 0, 0, 0, 0, 0);
    repeat (4)
      drive(1, 1, 5'd1, 2'b01, 1, 0, 1, 1, 1, 1);
    idle(3);

    // interrupt, mask window, re-take, stall blocking
    for (int i = 0; i < 6; i++)
      drive(1, 1, 5'd10, 2'b01, 0, 0, 1, i == 2,
            1, 1);
    drive(1, 1, 5'd11, 2'b01, 1, 0, 0, 0, 1, 1);
    drive(1, 1, 5'd11, 2'b01, 0, 0, 0, 0, 1, 1);
    idle(4);

    // write-enable corner tags
    drive(1, 1, 5'd5, 2'b11, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 5'd31, 2'b01, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 5'd5, 2'b01, 0, 0, 0, 0, 0, 0);
    idle(3);

    // random traffic with bursty freeze and rare resets
    busy = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      w = $urandom_range(0, 99);
      if (busy) busy = (w < 60);
      else      busy = (w < 12);
      if ($urandom_range(0, 299) == 0) begin
        drive(0, $urandom_range(0, 1),
              5'($urandom), 2'($urandom),
              1'($urandom), 1'($urandom),
              1'($urandom), busy,
              1'($urandom), 1'($urandom));
      end else begin
        drive(1,
              $urandom_range(0, 9) < 8,
              ($urandom_range(0, 7) == 0)
                ? 5'd31 : 5'($urandom),
              2'($urandom),
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 3) == 0,
              busy,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 9) < 7);
      end
    end

    w = 0;
    while (exp_q.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    #3;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d pending, expected 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
